// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default widths for the fetch/load memory port arbiter.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package mem_port_arbiter_pkg;

  localparam int DEF_ADDR_W       = 61;
  localparam int DEF_DATA_W       = 64;
  localparam int DEF_STARVE_LIMIT = 4;
  localparam int DEF_TIMEOUT      = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } arb_state_t;

  typedef enum logic {
    FETCH = 1'b0,
    LOAD  = 1'b1
  } owner_t;

  // Bits needed to hold a counter value from 0 up to maxVal inclusive.
  function automatic int cntWidth(input int maxVal);
    return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
  endfunction

endpackage

// File: rtl/mem_arb_select.sv
// Fetch/load winner selection: load priority, fetch forced after STARVE_LIMIT losses.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is committed.
module mem_arb_select
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int CNT_W        = cntWidth(DEF_STARVE_LIMIT)
) (
  input  logic             fetchReq,
  input  logic             loadReq,
  input  logic [CNT_W-1:0] starveCnt,
  output owner_t           winner,
  output logic [CNT_W-1:0] nextStarveCnt
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  // Pick the winner and the starvation count to commit alongside it.
  always_comb begin
    winner        = LOAD;
    nextStarveCnt = starveCnt;
    if (fetchReq && (!loadReq || (starveCnt == LIMIT))) begin
      winner        = FETCH;
      nextStarveCnt = '0;
    end else if (loadReq) begin
      winner = LOAD;
      // Only a waiting fetch counts as a loss; the count saturates at the limit.
      if (fetchReq && (starveCnt != LIMIT)) begin
        nextStarveCnt = starveCnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory read port between fetch and load, one transaction in flight.
// Latency: req cycle 0 -> mem_req/gnt cycle 1 -> mem_valid cycle 2 -> valid cycle 3 (minimum).
// Backpressure: mem_ready low holds REQ with mem_req/mem_addr stable; requesters hold req until gnt.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int TIMEOUT      = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  input  logic              load_req,
  input  logic [ADDR_W-1:0] load_addr,
  output logic              load_gnt,
  output logic              load_valid,
  output logic [DATA_W-1:0] load_data,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic              mem_valid,
  input  logic [DATA_W-1:0] mem_data,
  output logic              err
);

  localparam int SC_W = cntWidth(STARVE_LIMIT);
  localparam int WC_W = cntWidth(TIMEOUT);
  // The counter holds the number of WAIT cycles already spent, so the
  // TIMEOUT-th WAIT cycle is the one that sees TIMEOUT-1.
  localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(TIMEOUT - 1);

  arb_state_t        state;
  arb_state_t        stateNext;
  owner_t            owner;
  logic [ADDR_W-1:0] addrReg;
  logic [SC_W-1:0]   starveCnt;
  logic [WC_W-1:0]   waitCnt;
  logic              timeoutHit;
  logic              anyReq;
  owner_t            arbWinner;
  logic [SC_W-1:0]   arbNextStarve;

  assign anyReq = fetch_req | load_req;

  mem_arb_select #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (SC_W)
  ) u_select (
    .fetchReq      (fetch_req),
    .loadReq       (load_req),
    .starveCnt     (starveCnt),
    .winner        (arbWinner),
    .nextStarveCnt (arbNextStarve)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next state plus the combinational port outputs, including the same-cycle grant.
  always_comb begin
    stateNext   = state;
    mem_req     = 1'b0;
    mem_addr    = '0;
    fetch_gnt   = 1'b0;
    load_gnt    = 1'b0;
    fetch_valid = 1'b0;
    load_valid  = 1'b0;
    timeoutHit  = 1'b0;
    case (state)
      IDLE: begin
        if (anyReq) begin
          stateNext = REQ;
        end
      end
      REQ: begin
        mem_req  = 1'b1;
        mem_addr = addrReg;
        if (mem_ready) begin
          fetch_gnt = (owner == FETCH);
          load_gnt  = (owner == LOAD);
          stateNext = WAIT;
        end
      end
      WAIT: begin
        // Data arriving on the last allowed cycle still counts as a normal response.
        if (mem_valid) begin
          stateNext = RESP;
        end else if (waitCnt == WAIT_LAST) begin
          timeoutHit = 1'b1;
          stateNext  = RESP;
        end
      end
      RESP: begin
        fetch_valid = (owner == FETCH);
        load_valid  = (owner == LOAD);
        stateNext   = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Latch the arbitration result: owner, its address and the updated starvation count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner     <= FETCH;
      addrReg   <= '0;
      starveCnt <= '0;
    end else if ((state == IDLE) && anyReq) begin
      owner     <= arbWinner;
      addrReg   <= (arbWinner == FETCH) ? fetch_addr : load_addr;
      starveCnt <= arbNextStarve;
    end
  end

  // Count cycles spent in WAIT; cleared while the request is being presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waitCnt <= '0;
    end else if (state == REQ) begin
      waitCnt <= '0;
    end else if (state == WAIT) begin
      waitCnt <= waitCnt + 1'b1;
    end
  end

  // Capture read data (or all-ones on timeout) into the owner's register; err is sticky.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_data <= '0;
      load_data  <= '0;
      err        <= 1'b0;
    end else if (state == WAIT) begin
      if (mem_valid) begin
        if (owner == FETCH) begin
          fetch_data <= mem_data;
        end else begin
          load_data <= mem_data;
        end
      end else if (timeoutHit) begin
        err <= 1'b1;
        if (owner == FETCH) begin
          fetch_data <= '1;
        end else begin
          load_data <= '1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requester drivers, memory responder, negedge monitor.
// Latency: checks grant/valid cycle offsets against the documented minimum and stall cases.
// Backpressure: memory model can stall mem_ready or withhold mem_valid to force a timeout.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int AW = 61;
  localparam int DW = 64;

  typedef struct {
    owner_t        owner;
    logic [AW-1:0] addr;
  } grant_t;

  logic          clk;
  logic          rst_n;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          fetch_gnt;
  logic          fetch_valid;
  logic [DW-1:0] fetch_data;
  logic          load_req;
  logic [AW-1:0] load_addr;
  logic          load_gnt;
  logic          load_valid;
  logic [DW-1:0] load_data;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ready;
  logic          mem_valid;
  logic [DW-1:0] mem_data;
  logic          err;

  mem_port_arbiter #(
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .STARVE_LIMIT (4),
    .TIMEOUT      (255)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_gnt   (fetch_gnt),
    .fetch_valid (fetch_valid),
    .fetch_data  (fetch_data),
    .load_req    (load_req),
    .load_addr   (load_addr),
    .load_gnt    (load_gnt),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ready   (mem_ready),
    .mem_valid   (mem_valid),
    .mem_data    (mem_data),
    .err         (err)
  );

  int nTests = 0;
  int nFail  = 0;
  int cyc    = 0;

  // Requests waiting to be driven, expected grant order and expected response data.
  logic [AW-1:0] fetchQ[$];
  logic [AW-1:0] loadQ[$];
  grant_t        expQ[$];
  logic [DW-1:0] expFetchQ[$];
  logic [DW-1:0] expLoadQ[$];

  int fetchReqCyc, loadReqCyc, fetchGntCyc, loadGntCyc, fetchValidCyc, loadValidCyc;
  int fetchValidCnt = 0;
  int respDelay = 1;
  int respLeft  = 0;
  int stallLeft = 0;
  logic [AW-1:0] respAddr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nTests++;
    if (obs !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] dataFor(input logic [AW-1:0] a);
    if (a == 61'h10) return 64'hDEADBEEF00000001;
    return {a[31:0] ^ 32'h5A5A5A5A, ~a[31:0]};
  endfunction

  task automatic issueFetch(input logic [AW-1:0] a, input logic [DW-1:0] d);
    fetchQ.push_back(a);
    expFetchQ.push_back(d);
  endtask

  task automatic issueLoad(input logic [AW-1:0] a, input logic [DW-1:0] d);
    loadQ.push_back(a);
    expLoadQ.push_back(d);
  endtask

  task automatic expectGrant(input owner_t o, input logic [AW-1:0] a);
    grant_t g;
    g.owner = o;
    g.addr  = a;
    expQ.push_back(g);
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((expQ.size() + expFetchQ.size() + expLoadQ.size() + fetchQ.size() + loadQ.size()) != 0
           && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(n < budget), 64'd1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Fetch requester: holds req and address until granted.
  initial begin
    fetch_req  = 1'b0;
    fetch_addr = '0;
    forever begin
      @(posedge clk);
      #1;
      if (fetchQ.size() > 0 && rst_n) begin
        fetch_req   = 1'b1;
        fetch_addr  = fetchQ[0];
        fetchReqCyc = cyc;
        do @(negedge clk); while (!fetch_gnt);
        void'(fetchQ.pop_front());
        fetch_req = 1'b0;
      end
    end
  end

  // Load requester: re-raises immediately when more loads are queued.
  initial begin
    load_req  = 1'b0;
    load_addr = '0;
    forever begin
      @(posedge clk);
      #1;
      if (loadQ.size() > 0 && rst_n) begin
        load_req   = 1'b1;
        load_addr  = loadQ[0];
        loadReqCyc = cyc;
        do @(negedge clk); while (!load_gnt);
        void'(loadQ.pop_front());
        load_req = 1'b0;
      end
    end
  end

  // Memory responder: optional ready stall, response respDelay cycles after acceptance.
  initial begin
    mem_ready = 1'b1;
    mem_valid = 1'b0;
    mem_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_valid = 1'b0;
      if (respLeft > 0) begin
        respLeft--;
        if (respLeft == 0) begin
          mem_valid = 1'b1;
          mem_data  = dataFor(respAddr);
        end
      end
      if (mem_req && stallLeft > 0) begin
        mem_ready = 1'b0;
        stallLeft--;
      end else begin
        mem_ready = 1'b1;
      end
    end
  end

  // Monitor: grant order/address, per-requester response data, idle-port quietness.
  always @(negedge clk) begin
    grant_t g;
    if (mem_req) begin
      check("grant_expected", 64'(expQ.size() > 0), 64'd1);
      if (expQ.size() > 0) begin
        g = expQ[0];
        check("mem_addr", 64'(mem_addr), 64'(g.addr));
        check("gnt_pair", {62'd0, fetch_gnt, load_gnt},
              mem_ready ? ((g.owner == LOAD) ? 64'd1 : 64'd2) : 64'd0);
        if (mem_ready) begin
          void'(expQ.pop_front());
          respLeft = respDelay;
          respAddr = mem_addr;
          if (g.owner == LOAD) loadGntCyc = cyc;
          else fetchGntCyc = cyc;
        end
      end
    end else begin
      check("idle_addr", 64'(mem_addr), 64'd0);
      check("idle_gnt", {62'd0, fetch_gnt, load_gnt}, 64'd0);
    end
    if (fetch_gnt) check("starve_clr", 64'(dut.starveCnt), 64'd0);
    if (fetch_valid) begin
      fetchValidCnt++;
      fetchValidCyc = cyc;
      check("valid_excl", 64'(load_valid), 64'd0);
      check("fetch_valid_expected", 64'(expFetchQ.size() > 0), 64'd1);
      if (expFetchQ.size() > 0) check("fetch_data", fetch_data, expFetchQ.pop_front());
    end
    if (load_valid) begin
      loadValidCyc = cyc;
      check("load_valid_expected", 64'(expLoadQ.size() > 0), 64'd1);
      if (expLoadQ.size() > 0) check("load_data", load_data, expLoadQ.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int vcnt;
    int n;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ctl", {58'd0, fetch_gnt, fetch_valid, load_gnt, load_valid, mem_req, err}, 64'd0);
    check("rst_fdata", fetch_data, 64'd0);
    check("rst_ldata", load_data, 64'd0);
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_state", 64'(dut.state), 64'(IDLE));
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Fetch only, minimum latency.
    @(negedge clk);
    expectGrant(FETCH, 61'h10);
    issueFetch(61'h10, 64'hDEADBEEF00000001);
    drain("t1_drain", 50);
    check("t1_gnt_lat", 64'(fetchGntCyc - fetchReqCyc), 64'd1);
    check("t1_val_lat", 64'(fetchValidCyc - fetchReqCyc), 64'd3);
    check("t1_hold", fetch_data, 64'hDEADBEEF00000001);

    // Simultaneous requests: load first, fetch next.
    expectGrant(LOAD, 61'h40);
    expectGrant(FETCH, 61'h20);
    issueFetch(61'h20, dataFor(61'h20));
    issueLoad(61'h40, dataFor(61'h40));
    drain("t2_drain", 60);

    // Starvation: fetch forced through after four load wins.
    issueFetch(61'h100, dataFor(61'h100));
    for (int i = 0; i < 6; i++) issueLoad(61'h200 + 61'(i), dataFor(61'h200 + 61'(i)));
    for (int i = 0; i < 4; i++) expectGrant(LOAD, 61'h200 + 61'(i));
    expectGrant(FETCH, 61'h100);
    expectGrant(LOAD, 61'h204);
    expectGrant(LOAD, 61'h205);
    drain("t3_drain", 150);
    check("t3_starve", 64'(dut.starveCnt), 64'd0);

    // Backpressure: five cycles of mem_ready low.
    stallLeft = 5;
    expectGrant(LOAD, 61'h80);
    issueLoad(61'h80, dataFor(61'h80));
    drain("t4_drain", 60);
    check("t4_gnt_lat", 64'(loadGntCyc - loadReqCyc), 64'd6);

    // Timeout: memory never answers.
    check("t5_err_before", 64'(err), 64'd0);
    respDelay = 0;
    expectGrant(LOAD, 61'h99);
    issueLoad(61'h99, '1);
    drain("t5_drain", 400);
    check("t5_err", 64'(err), 64'd1);
    check("t5_lat", 64'(loadValidCyc - loadGntCyc), 64'd256);
    respDelay = 1;
    expectGrant(FETCH, 61'h10);
    issueFetch(61'h10, 64'hDEADBEEF00000001);
    drain("t5b_drain", 50);
    check("t5_err_sticky", 64'(err), 64'd1);

    // Reset in WAIT, then a late mem_valid.
    respDelay = 3;
    expectGrant(FETCH, 61'h30);
    issueFetch(61'h30, dataFor(61'h30));
    n = 0;
    while (expQ.size() > 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t6_gnt_seen", 64'(n < 20), 64'd1);
    @(posedge clk);
    #1;
    check("t6_in_wait", 64'(dut.state), 64'(WAIT));
    rst_n = 1'b0;
    expFetchQ.delete();
    expQ.delete();
    vcnt = fetchValidCnt;
    @(negedge clk);
    check("t6_rst_err", 64'(err), 64'd0);
    check("t6_rst_fdata", fetch_data, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("t6_no_valid", 64'(fetchValidCnt), 64'(vcnt));
    check("t6_err", 64'(err), 64'd0);
    check("t6_state", 64'(dut.state), 64'(IDLE));
    check("t6_fdata", fetch_data, 64'd0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 61, meaning doubleword address width.
REQ-002 The block SHALL have parameter DATA_W, default 64, meaning memory data width.
REQ-003 The block SHALL have parameter STARVE_LIMIT, default 4, meaning the number of consecutive fetch losses that forces a fetch win.
REQ-004 The block SHALL have parameter TIMEOUT, default 255, meaning the maximum WAIT cycles before error.
REQ-005 The block SHALL have ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- fetch_req  in  1  instruction fetch request; held until fetch_gnt.
- fetch_addr  in  ADDR_W  fetch doubleword address.
- fetch_gnt  out  1  one-cycle pulse: fetch accepted by memory.
- fetch_valid  out  1  one-cycle pulse: fetch_data valid.
- fetch_data  out  DATA_W  fetch read data.
- load_req  in  1  load request; held until load_gnt.
- load_addr  in  ADDR_W  load doubleword address.
- load_gnt  out  1  one-cycle pulse: load accepted.
- load_valid  out  1  one-cycle pulse: load_data valid.
- load_data  out  DATA_W  load read data.
- mem_req  out  1  request to the shared memory read port.
- mem_addr  out  ADDR_W  shared port address.
- mem_ready  in  1  memory accepts mem_req this cycle.
- mem_valid  in  1  memory read data returned.
- mem_data  in  DATA_W  memory read data.
- err  out  1  sticky timeout error.

Function
REQ-006 The FSM SHALL have states IDLE, REQ, WAIT, RESP; exactly one transaction outstanding at a time.
REQ-007 In IDLE with any request, the FSM SHALL register the winner (owner) and its address, then go to REQ.
REQ-008 Arbitration SHALL give load priority, except that fetch SHALL win when starve_cnt equals STARVE_LIMIT.
REQ-009 starve_cnt SHALL increment, saturating, when fetch_req is asserted but load wins; it SHALL clear when fetch wins.
REQ-010 In REQ, mem_req SHALL be 1 and mem_addr SHALL be the registered address; mem_addr SHALL be 0 in all other states.
REQ-011 In REQ with mem_ready=1, the owner's gnt SHALL pulse high combinationally in that cycle, and the FSM SHALL go to WAIT; otherwise it stays in REQ.
REQ-012 In WAIT, mem_valid=1 SHALL capture mem_data into the owner's data register and move the FSM to RESP.
REQ-013 In RESP, the owner's valid SHALL be 1 for exactly one cycle, then the FSM SHALL go to IDLE; the data register SHALL hold until it is next overwritten.
REQ-014 Minimum latency SHALL be: req at cycle 0, mem_req at cycle 1, gnt at cycle 1 (mem_ready=1), mem_valid at cycle 2, owner valid at cycle 3.
REQ-015 A wait counter SHALL count WAIT cycles; on reaching TIMEOUT, err SHALL set, owner data SHALL be all-ones, and the FSM SHALL go to RESP.
REQ-016 mem_valid outside WAIT SHALL be ignored without side effect.
REQ-017 Requests arriving in non-IDLE states SHALL wait; both requests asserted simultaneously SHALL be resolved per REQ-008 with no loss.
REQ-018 A requester dropping req before gnt is a protocol violation; the arbiter SHALL complete the latched transaction regardless.

Reset
REQ-019 On rst_n=0, asynchronously: FSM to IDLE; starve_cnt, the wait counter, and the owner cleared; all outputs 0, including data and err.
REQ-020 A reset mid-transaction SHALL abandon the transaction; a late mem_valid SHALL be dropped per REQ-016.

Structure
REQ-021 The state enum, owner encoding (FETCH, LOAD), and default widths SHALL live in package mem_port_arbiter_pkg.
REQ-022 The priority/starvation logic SHALL be one sub-module, mem_arb_select (inputs: both reqs and starve_cnt; outputs: winner and next starve_cnt).

Verification
REQ-023 Fetch-only: fetch_addr=0x10 with mem_ready=1 and mem_valid one cycle later, data 0xDEADBEEF00000001 -> fetch_gnt at cycle 1, fetch_valid at cycle 3 with that data.
REQ-024 Simultaneous: fetch_addr=0x20 and load_addr=0x40 at cycle 0 -> mem_addr 0x40 first, then 0x20; both valids are delivered in order.
REQ-025 Starvation: load_req held constantly with fetch_req held -> fetch is granted after exactly 4 load grants, and starve_cnt then reads 0.
REQ-026 Backpressure: mem_ready=0 for 5 cycles -> mem_req and mem_addr are held stable, no gnt appears, and gnt pulses in the cycle mem_ready rises.
REQ-027 Timeout: no mem_valid for 255 WAIT cycles -> err=1, owner valid pulses with all-ones data, and err stays 1 until reset.
REQ-028 Reset mid-WAIT followed by mem_valid -> no valid pulse, err=0, and the FSM is in IDLE.
